mul12_seq_ctrl: RTL and testbench
=================================

// Module: mul12_seq_ctrl
// PURPOSE
//   Sequencer that builds an unsigned 12x12 -> 24-bit multiply from one internal dadda_mul6x6 core.
//   The core is reused over four passes, one 6x6 sub-product per pass, summed into a 24-bit accumulator.
//   Operand input and result output each use a valid/ready handshake.
//   Sits between the operand-issuing datapath and result consumers wherever a 12-bit product is
//   needed without paying for a full 12x12 tree.
// PARAMETERS
//   CORE_W  6   width of the dadda_mul6x6 core operands; only 6 is supported
//   OP_W    12  operand width, fixed at 2*CORE_W; result width is 2*OP_W = 24
// PORTS
//   clk        in   1   single clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   flush      in   1   synchronous abort; drops any in-flight op or held result
//   in_valid   in   1   operand pair valid
//   in_ready   out  1   block can accept an operand pair
//   in_a       in   12  multiplicand, unsigned
//   in_b       in   12  multiplier, unsigned
//   out_valid  out  1   out_p holds a completed product
//   out_ready  in   1   consumer accepts out_p
//   out_p      out  24  product in_a*in_b
//   busy       out  1   high in MUL state
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, pass_cnt=0, acc=0, latched a/b=0.
//     Outputs: out_valid=0, out_p=0, busy=0, in_ready=1 once rst_n=1.
//   States and transitions:
//     IDLE: in_ready=1. Accept on in_valid&in_ready: latch a/b, acc<=0, pass_cnt<=0, go to MUL.
//     MUL: in_ready=0, busy=1, 4 cycles with pass_cnt 0..3. The core is driven from the latched operands.
//       Each edge: acc <= acc + (core_p << sh).
//         pass 0: a[5:0]*b[5:0], sh=0
//         pass 1: a[5:0]*b[11:6], sh=6
//         pass 2: a[11:6]*b[5:0], sh=6
//         pass 3: a[11:6]*b[11:6], sh=12
//       After pass 3: go to DONE.
//     DONE: out_valid=1; out_p=acc and stays stable while out_ready=0.
//       in_ready = out_ready. This is the only case where in_ready is high outside IDLE.
//       out_ready=1 and in_valid=1: result retired and new op accepted on the same edge -> MUL.
//       out_ready=1 and in_valid=0: -> IDLE.
//   Latency: out_valid is first high on the 4th rising edge after the accepting edge.
//     Peak throughput is one op per 5 cycles.
//   Width: 4095^2 < 2^24, so the accumulator never overflows. No saturation and no wrap handling.
//   flush=1 (sync, wins over all handshakes): next edge -> IDLE, out_valid=0, acc=0.
//     An in_valid in the same cycle is NOT accepted.
//   Async reset mid-pass: op lost, no out_valid ever asserted for it.
//     The next op after reset is computed correctly.
//   in_a/in_b may change freely after acceptance; only the latched copies are used.
//   Handshake rules: in_valid and out_ready may toggle at any time.
//     out_p/out_valid must not change while out_valid=1 and out_ready=0, except on flush or reset.
// TESTING
//   1. a=12'hFFF, b=12'hFFF, accepted at edge E -> out_valid at E+4, out_p=24'hFFE001.
//   2. a=12'h03F, b=12'h040 (cross terms only) -> out_p=24'h000FC0.
//      a=0, b=12'hABC -> out_p=0.
//   3. Backpressure: out_ready=0 for 10 cycles after out_valid.
//      -> out_p stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next edge.
//   4. Back-to-back: in_valid held high, out_ready=1 -> in_ready pulses in DONE.
//      New op accepted on the retire edge; 20 random pairs give results 5 cycles apart, all match a*b.
//   5. rst_n=0 during pass 2 of 12'h123*12'h456.
//      -> all outputs 0 immediately, no out_valid; then 12'h123*12'h456 -> 24'h04EDC2.
//   6. flush=1 with in_valid=1 in MUL, and again in DONE.
//      -> IDLE, out_valid=0, in_valid not accepted that cycle.

Source files
------------

// File: rtl/mul12_seq_ctrl.sv
// Sequential unsigned 12x12 -> 24 multiplier built from a single 6x6 core.
// The core is reused over four passes; sub-products are shifted and summed
// into a 24-bit accumulator. Operands and result use valid/ready handshakes.

// 6x6 unsigned multiply core: partial products summed (adder tree on synthesis).
module dadda_mul6x6 (
   input  logic [5:0]  a,
   input  logic [5:0]  b,
   output logic [11:0] p
);

   // sum of the six shifted partial products
   always_comb begin
      p = '0;
      for (int unsigned i = 0; i < 6; i++) begin
         if (b[i]) p = p + ({6'b0, a} << i);
      end
   end

endmodule

module mul12_seq_ctrl #(
   parameter int CORE_W = 6,
   parameter int OP_W   = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_a,
   input  logic [OP_W-1:0]   in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*OP_W-1:0] out_p,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          pass_q;
   logic [2*OP_W-1:0]   acc_q;
   logic [OP_W-1:0]     a_q, b_q;
   logic [CORE_W-1:0]   core_a, core_b;
   logic [2*CORE_W-1:0] core_p;
   logic [3:0]          sh;
   logic                load;

   // select the operand halves and weight for the current pass
   always_comb begin
      core_a = a_q[CORE_W-1:0];
      core_b = b_q[CORE_W-1:0];
      sh     = 4'd0;
      case (pass_q)
         2'd0: begin
            core_a = a_q[CORE_W-1:0];
            core_b = b_q[CORE_W-1:0];
            sh     = 4'd0;
         end
         2'd1: begin
            core_a = a_q[CORE_W-1:0];
            core_b = b_q[OP_W-1:CORE_W];
            sh     = 4'd6;
         end
         2'd2: begin
            core_a = a_q[OP_W-1:CORE_W];
            core_b = b_q[CORE_W-1:0];
            sh     = 4'd6;
         end
         default: begin
            core_a = a_q[OP_W-1:CORE_W];
            core_b = b_q[OP_W-1:CORE_W];
            sh     = 4'd12;
         end
      endcase
   end

   dadda_mul6x6 u_core (
      .a (core_a),
      .b (core_b),
      .p (core_p)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next state, handshake outputs and operand load strobe; flush overrides all
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      load      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load    = 1'b1;
               state_d = MUL;
            end
         end
         MUL: begin
            busy = 1'b1;
            if (pass_q == 2'd3) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               load    = in_valid;
               state_d = in_valid ? MUL : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         load    = 1'b0;
         state_d = IDLE;
      end
   end

   // operand latch, pass counter and accumulator
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         acc_q  <= '0;
         pass_q <= '0;
      end else if (flush) begin
         acc_q  <= '0;
         pass_q <= '0;
      end else if (load) begin
         a_q    <= in_a;
         b_q    <= in_b;
         acc_q  <= '0;
         pass_q <= '0;
      end else if (state_q == MUL) begin
         acc_q  <= acc_q + ({{(2*OP_W-2*CORE_W){1'b0}}, core_p} << sh);
         pass_q <= pass_q + 2'd1;
      end
   end

   // the product is only presented while it is valid
   always_comb begin
      out_p = (state_q == DONE) ? acc_q : '0;
   end

endmodule

// File: tb/tb_mul12_seq_ctrl.sv
// Scoreboard bench for mul12_seq_ctrl: the driver pushes a*b on every accepted
// operand pair, a separate monitor checks results, latency, hold and handshakes.
module tb_mul12_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] in_a = '0;
   logic [11:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [23:0] out_p;
   logic        busy;

   typedef struct {
      logic [23:0] p;
      int          c;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   acc_ok = 1'b0;
   int   last_acc = 0;

   mul12_seq_ctrl #(.CORE_W(6), .OP_W(12)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .busy      (busy)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [23:0] model(input logic [11:0] a, input logic [11:0] b);
      return 24'(a) * 24'(b);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // one cycle: sample the input handshake late in the cycle, then move to next negedge
   task automatic step(output bit acc);
      #4;
      acc = rst_n && !flush && in_valid && in_ready;
      if (acc) begin
         sb.push_back('{p: model(in_a, in_b), c: cyc});
         acc_ok   = 1'b1;
         last_acc = cyc;
      end
      @(negedge clk);
   endtask

   task automatic issue(input logic [11:0] a, input logic [11:0] b);
      bit acc;
      acc      = 1'b0;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(acc);
         if (acc) break;
      end
      chk("accept_timeout", acc, 1);
      in_valid = 1'b0;
      in_a     = 12'($urandom);
      in_b     = 12'($urandom);
   endtask

   task automatic run_until_valid();
      bit acc;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) break;
         step(acc);
      end
      chk("valid_timeout", out_valid, 1);
   endtask

   // monitor: decoupled from the driver, samples 4ns after each negedge
   initial begin
      bit          hold;
      bit          seen;
      bit          bexp;
      logic [23:0] prev_p;
      int          d;
      hold   = 1'b0;
      seen   = 1'b0;
      prev_p = '0;
      forever begin
         @(negedge clk);
         #4;
         if (!rst_n) begin
            sb.delete();
            hold   = 1'b0;
            seen   = 1'b0;
            acc_ok = 1'b0;
         end else begin
            d    = cyc - last_acc;
            bexp = acc_ok && d >= 1 && d <= 4;
            chk("busy", busy, bexp);
            chk("in_ready", in_ready, out_valid ? out_ready : !bexp);
            if (hold) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_p", out_p, prev_p);
            end
            if (out_valid) begin
               if (sb.size() == 0) begin
                  chk("spurious_valid", out_valid, 0);
               end else begin
                  if (!seen) begin
                     chk("latency", cyc - sb[0].c, 5);
                     seen = 1'b1;
                  end
                  if (out_ready && !flush) begin
                     chk("product", out_p, sb[0].p);
                     void'(sb.pop_front());
                     seen = 1'b0;
                  end
               end
            end
            hold   = out_valid && !out_ready && !flush;
            prev_p = out_p;
            if (flush) begin
               sb.delete();
               seen   = 1'b0;
               acc_ok = 1'b0;
            end
         end
      end
   end

   // stimulus
   initial begin
      bit acc;
      int n;
      int prev;

      repeat (3) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_p", out_p, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      step(acc);
      chk("rst_in_ready", in_ready, 1);

      // directed products
      out_ready = 1'b1;
      issue(12'hFFF, 12'hFFF);
      run_until_valid();
      chk("max_product", out_p, 24'hFFE001);
      step(acc);
      issue(12'h03F, 12'h040);
      run_until_valid();
      chk("cross_product", out_p, 24'h000FC0);
      step(acc);
      issue(12'h000, 12'hABC);
      run_until_valid();
      chk("zero_product", out_p, 24'h000000);
      step(acc);

      // backpressure: result held 10 cycles, new operands refused
      out_ready = 1'b0;
      issue(12'($urandom), 12'($urandom));
      run_until_valid();
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_a = 12'($urandom);
         in_b = 12'($urandom);
         step(acc);
         chk("bp_no_accept", acc, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step(acc);
      chk("bp_idle_ready", in_ready, 1);
      chk("bp_valid_low", out_valid, 0);

      // back-to-back: 20 ops, one accepted every 5 cycles
      in_valid = 1'b1;
      in_a     = 12'($urandom);
      in_b     = 12'($urandom);
      n        = 0;
      prev     = 0;
      for (int i = 0; i < 150 && n < 20; i++) begin
         step(acc);
         if (acc) begin
            if (n > 0) chk("b2b_spacing", last_acc - prev, 5);
            prev = last_acc;
            n++;
            in_a = 12'($urandom);
            in_b = 12'($urandom);
         end
      end
      chk("b2b_count", n, 20);
      in_valid = 1'b0;
      run_until_valid();
      step(acc);

      // async reset during pass 2
      issue(12'h123, 12'h456);
      step(acc);
      step(acc);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_p", out_p, 0);
      chk("midrst_busy", busy, 0);
      @(negedge clk);
      step(acc);
      rst_n = 1'b1;
      step(acc);
      chk("midrst_in_ready", in_ready, 1);
      issue(12'h123, 12'h456);
      run_until_valid();
      chk("midrst_recover_p", out_p, 24'h04EDC2);
      step(acc);

      // flush in MUL with a competing in_valid
      issue(12'($urandom), 12'($urandom));
      step(acc);
      flush    = 1'b1;
      in_valid = 1'b1;
      step(acc);
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_mul_busy", busy, 0);
      chk("flush_mul_valid", out_valid, 0);
      chk("flush_mul_ready", in_ready, 1);
      repeat (6) step(acc);

      // flush in DONE with a competing in_valid
      out_ready = 1'b0;
      issue(12'($urandom), 12'($urandom));
      run_until_valid();
      flush    = 1'b1;
      in_valid = 1'b1;
      step(acc);
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_done_valid", out_valid, 0);
      chk("flush_done_busy", busy, 0);
      chk("flush_done_p", out_p, 0);
      out_ready = 1'b1;
      repeat (6) step(acc);

      // random traffic with occasional flush
      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom % 4) != 0;
         flush     = ($urandom % 32) == 0;
         in_a      = 12'($urandom);
         in_b      = 12'($urandom);
         step(acc);
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (8) step(acc);
      chk("queue_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
